// File: rtl/pool_flatten_pkg.sv
// Shared types and constants for the pooling/flatten engine.
package pool_flatten_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD0,
      S_RD1,
      S_RD2,
      S_RD3,
      S_LAST,
      S_WR1,
      S_WR2,
      S_DONE
   } state_t;

   localparam logic MODE_MAX = 1'b0;
   localparam logic MODE_AVG = 1'b1;

   // Memory-select codes; 0 means no memory selected.
   function automatic int unsigned l0_sel(input int unsigned c);
      return 1 + c;
   endfunction

   function automatic int unsigned l1_sel(input int unsigned c, input int unsigned n_ch);
      return 1 + n_ch + c;
   endfunction

   function automatic int unsigned l2_sel(input int unsigned n_ch);
      return 1 + 2 * n_ch;
   endfunction

endpackage

// File: rtl/pool_flatten_if.sv
// Shared read/write memory port between the engine and the feature-map memories.
interface pool_flatten_if #(
   parameter int DW  = 20,
   parameter int AW  = 12,
   parameter int CSW = 3
);
   logic           crd;
   logic [AW-1:0]  caddr_rd;
   logic [DW-1:0]  cdata_rd;
   logic           cwr;
   logic [AW-1:0]  caddr_wr;
   logic [DW-1:0]  cdata_wr;
   logic [CSW-1:0] csel;

   modport master (
      output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
      input  cdata_rd
   );

   modport slave (
      input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
      output cdata_rd
   );
endinterface

// File: rtl/pool_flatten_reduce4.sv
// Four-sample reducer: running signed max and a widened sum for rounded average.
module pool_reduce4
   import pool_flatten_pkg::*;
#(
   parameter int DW = 20
) (
   input  logic          clk_sys,
   input  logic          rst_b,
   input  logic          clear,
   input  logic          valid,
   input  logic [DW-1:0] data,
   input  logic          mode,
   output logic [DW-1:0] result
);

   localparam int SW = DW + 2;

   logic signed [DW-1:0] data_s;
   logic signed [DW-1:0] max_q, max_d;
   logic signed [SW-1:0] sum_q, sum_d;
   logic signed [SW-1:0] avg;

   // Accumulate; result reflects the sample arriving this cycle so the last tap is usable immediately.
   always_comb begin
      data_s = $signed(data);
      max_d  = max_q;
      sum_d  = sum_q;
      if (valid) begin
         if (clear) begin
            max_d = data_s;
            sum_d = SW'(data_s);
         end else begin
            if (data_s > max_q) max_d = data_s;
            sum_d = sum_q + SW'(data_s);
         end
      end
      avg    = (sum_d + SW'(2)) >>> 2;
      result = (mode == MODE_AVG) ? avg[DW-1:0] : max_d;
   end

   // Accumulator registers.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         max_q <= '0;
         sum_q <= '0;
      end else begin
         max_q <= max_d;
         sum_q <= sum_d;
      end
   end

endmodule

// File: rtl/pool_flatten.sv
// 2x2 stride-2 pooling (max / rounded average) plus channel-interleaved flatten.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RD0  | read tap 0 (base)
// S_RD1  | read tap 1 (base+1), tap 0 data arrives
// S_RD2  | read tap 2 (base+IMG_W), tap 1 data arrives
// S_RD3  | read tap 3 (base+IMG_W+1), tap 2 data arrives
// S_LAST | tap 3 data arrives
// S_WR1  | write result to layer-1 channel c, address p
// S_WR2  | write result to layer 2, address p*N_CH+c
// S_DONE | one-cycle completion pulse
module pool_flatten
   import pool_flatten_pkg::*;
#(
   parameter int DW    = 20,
   parameter int IMG_W = 64,
   parameter int N_CH  = 2,
   parameter int AW    = $clog2(IMG_W * IMG_W),
   parameter int CSW   = $clog2(2 * N_CH + 2)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           mode,
   output logic           busy,
   output logic           done,
   pool_flatten_if.master mem
);

   localparam int PW = $clog2(IMG_W / 2);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [PW-1:0] P_MAX  = PW'(IMG_W / 2 - 1);
   localparam logic [CW-1:0] CH_MAX = CW'(N_CH - 1);

   state_t          state_q, state_d;
   logic [PW-1:0]   px_q, px_d, py_q, py_d;
   logic [CW-1:0]   c_q, c_d;
   logic [1:0]      tap_q, tap_d;
   logic            mode_q, mode_d;

   logic            busy_q, busy_d, done_q, done_d;
   logic            crd_q, crd_d, cwr_q, cwr_d;
   logic [AW-1:0]   caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
   logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
   logic [CSW-1:0]  csel_q, csel_d;

   logic            red_clear, red_valid;
   logic [DW-1:0]   red_result;
   logic [AW-1:0]   p_addr;

   pool_reduce4 #(.DW(DW)) u_reduce (
      .clk_sys (clk),
      .rst_b   (reset),
      .clear   (red_clear),
      .valid   (red_valid),
      .data    (mem.cdata_rd),
      .mode    (mode_q),
      .result  (red_result)
   );

   // Next state, counters, and the registered outputs decoded from the next state.
   always_comb begin
      state_d   = state_q;
      px_d      = px_q;
      py_d      = py_q;
      c_d       = c_q;
      tap_d     = '0;
      mode_d    = mode_q;
      red_clear = 1'b0;
      red_valid = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_RD0;
               mode_d  = mode;
            end
         end
         S_RD0: begin
            state_d = S_RD1;
            tap_d   = tap_q + 2'd1;
         end
         S_RD1: begin
            state_d   = S_RD2;
            tap_d     = tap_q + 2'd1;
            red_clear = 1'b1;
            red_valid = 1'b1;
         end
         S_RD2: begin
            state_d   = S_RD3;
            tap_d     = tap_q + 2'd1;
            red_valid = 1'b1;
         end
         S_RD3: begin
            state_d   = S_LAST;
            red_valid = 1'b1;
         end
         S_LAST: begin
            state_d   = S_WR1;
            red_valid = 1'b1;
         end
         S_WR1: state_d = S_WR2;
         S_WR2: begin
            state_d = S_RD0;
            if (c_q != CH_MAX) begin
               c_d = c_q + CW'(1);
            end else begin
               c_d = '0;
               if (px_q != P_MAX) begin
                  px_d = px_q + PW'(1);
               end else begin
                  px_d = '0;
                  if (py_q != P_MAX) begin
                     py_d = py_q + PW'(1);
                  end else begin
                     py_d    = '0;
                     state_d = S_DONE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      p_addr     = AW'({py_d, px_d});
      crd_d      = 1'b0;
      cwr_d      = 1'b0;
      caddr_rd_d = '0;
      caddr_wr_d = '0;
      cdata_wr_d = '0;
      csel_d     = '0;

      case (state_d)
         S_RD0, S_RD1, S_RD2, S_RD3: begin
            crd_d      = 1'b1;
            caddr_rd_d = {py_d, tap_d[1], px_d, tap_d[0]};
            csel_d     = CSW'(l0_sel(32'(c_d)));
         end
         S_WR1: begin
            cwr_d      = 1'b1;
            caddr_wr_d = p_addr;
            cdata_wr_d = red_result;
            csel_d     = CSW'(l1_sel(32'(c_d), N_CH));
         end
         S_WR2: begin
            cwr_d      = 1'b1;
            caddr_wr_d = p_addr * AW'(N_CH) + AW'(c_d);
            cdata_wr_d = red_result;
            csel_d     = CSW'(l2_sel(N_CH));
         end
         default: ;
      endcase

      busy_d = state_d inside {S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_WR1, S_WR2};
      done_d = (state_d == S_DONE);
   end

   // State, counter and output registers; reset abandons any pixel in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         px_q       <= '0;
         py_q       <= '0;
         c_q        <= '0;
         tap_q      <= '0;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         crd_q      <= 1'b0;
         cwr_q      <= 1'b0;
         caddr_rd_q <= '0;
         caddr_wr_q <= '0;
         cdata_wr_q <= '0;
         csel_q     <= '0;
      end else begin
         state_q    <= state_d;
         px_q       <= px_d;
         py_q       <= py_d;
         c_q        <= c_d;
         tap_q      <= tap_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         crd_q      <= crd_d;
         cwr_q      <= cwr_d;
         caddr_rd_q <= caddr_rd_d;
         caddr_wr_q <= caddr_wr_d;
         cdata_wr_q <= cdata_wr_d;
         csel_q     <= csel_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign mem.crd      = crd_q;
   assign mem.cwr      = cwr_q;
   assign mem.caddr_rd = caddr_rd_q;
   assign mem.caddr_wr = caddr_wr_q;
   assign mem.cdata_wr = cdata_wr_q;
   assign mem.csel     = csel_q;

endmodule
